mib_slave_bridge: RTL and testbench

- Slave end of the inter-FPGA MIB bus; the stage directly downstream of mib_master.
- Decodes MIB address/data phases for this FPGA's 4-bit address nibble.
- Issues one 32-bit local cmd-bus transaction per MIB transfer and returns read data or a write ack on the shared 16-bit AD bus.
- Instantiated once in each cs top, between the top-level AD tri-state pads and the local register/cmd fabric.

---
 rtl/mib_slave_bridge.sv | 242 ++++++++++++++++++++++++
 tb/tb_mib_slave_bridge.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mib_slave_bridge.sv
// MIB slave bridge: decodes MIB address/data phases for this FPGA's address nibble and
// runs one local cmd-bus transaction per transfer. Optional counters: MIB_SLAVE_STATS_EN.
module mib_slave_bridge #(
    parameter logic [3:0]  P_SLAVE_MSN            = 4'h0,
    parameter int          P_CMD_ACK_TIMEOUT_CLKS = 16,
    parameter logic [31:0] P_TIMEOUT_RDATA        = 32'hDEAD_BEEF
) (
    input  logic        i_sysclk,
    input  logic        i_arst_n,
    input  logic        i_mib_start,
    input  logic        i_mib_rd_wr_n,
    input  logic [15:0] i_mib_ad,
    output logic [15:0] o_mib_ad,
    output logic        o_mib_ad_oe,
    output logic        o_mib_slave_ack,
    output logic        o_cmd_sel,
    output logic        o_cmd_rd_wr_n,
    output logic [19:0] o_cmd_byte_addr,
    output logic [31:0] o_cmd_wdata,
    input  logic        i_cmd_ack,
    input  logic [31:0] i_cmd_rdata,
    output logic        o_cmd_timeout
`ifdef MIB_SLAVE_STATS_EN
    ,
    output logic [15:0] o_stat_wr_cnt,
    output logic [15:0] o_stat_rd_cnt,
    output logic [15:0] o_stat_to_cnt
`endif
);

    localparam int CNT_W = $clog2(P_CMD_ACK_TIMEOUT_CLKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_CMD_ACK_TIMEOUT_CLKS - 1);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_ADDR2   = 4'd1,
        ST_WR_HI   = 4'd2,
        ST_WR_LO   = 4'd3,
        ST_WR_CMD  = 4'd4,
        ST_RD_CMD  = 4'd5,
        ST_RD_TURN = 4'd6,
        ST_RD_HI   = 4'd7,
        ST_RD_LO   = 4'd8,
        ST_SKIP    = 4'd9
    } state_t;

    logic [1:0]       rst_sync_r;
    logic             rst_n_s;
    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             rd_wr_n_r;
    logic [3:0]       addr_hi_r;
    logic [15:0]      addr_lo_r;
    logic [15:0]      wdata_hi_r;
    logic [31:0]      rdata_r;
    logic             cmd_sel_s;
    logic [19:0]      cmd_addr_s;
    logic [31:0]      cmd_wdata_s;
    logic             wr_ack_s;
    logic             timeout_s;
    logic             rdata_ld_s;
    logic [31:0]      rdata_nxt_s;
    logic             rd_drive_s;

    // Reset synchronizer: asynchronous assertion, deassertion aligned to i_sysclk
    always_ff @(posedge i_sysclk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_n_s = rst_sync_r[1];

    // Next-state and per-cycle strobes for the MIB/cmd sequencing
    always_comb begin
        state_s     = state_r;
        cnt_s       = {CNT_W{1'b0}};
        cmd_sel_s   = 1'b0;
        cmd_addr_s  = {addr_hi_r, addr_lo_r};
        cmd_wdata_s = {wdata_hi_r, i_mib_ad};
        wr_ack_s    = 1'b0;
        timeout_s   = 1'b0;
        rdata_ld_s  = 1'b0;
        rdata_nxt_s = P_TIMEOUT_RDATA;
        case (state_r)
            ST_IDLE: begin
                if (i_mib_start) begin
                    if (i_mib_ad[7:4] == P_SLAVE_MSN) begin
                        state_s = ST_ADDR2;
                    end else begin
                        state_s = ST_SKIP;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SKIP: state_s = ST_IDLE;
            ST_ADDR2: begin
                // Read request goes out while the low address is still on the bus
                cmd_addr_s = {addr_hi_r, i_mib_ad};
                if (rd_wr_n_r) begin
                    state_s   = ST_RD_CMD;
                    cmd_sel_s = 1'b1;
                end else begin
                    state_s = ST_WR_HI;
                end
            end
            ST_WR_HI: state_s = ST_WR_LO;
            ST_WR_LO: begin
                state_s   = ST_WR_CMD;
                cmd_sel_s = 1'b1;
            end
            ST_WR_CMD: begin
                if (i_cmd_ack) begin
                    state_s  = ST_IDLE;
                    wr_ack_s = 1'b1;
                end else if (cnt_r == CNT_LAST) begin
                    state_s   = ST_IDLE;
                    wr_ack_s  = 1'b1;
                    timeout_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_RD_CMD: begin
                if (i_cmd_ack) begin
                    state_s     = ST_RD_TURN;
                    rdata_ld_s  = 1'b1;
                    rdata_nxt_s = i_cmd_rdata;
                end else if (cnt_r == CNT_LAST) begin
                    state_s    = ST_RD_TURN;
                    rdata_ld_s = 1'b1;
                    timeout_s  = 1'b1;
                end else begin
                    cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_RD_TURN: state_s = ST_RD_HI;
            ST_RD_HI:   state_s = ST_RD_LO;
            ST_RD_LO:   state_s = ST_IDLE;
            default:    state_s = ST_IDLE;
        endcase
    end

    assign rd_drive_s = (state_s == ST_RD_HI) || (state_s == ST_RD_LO);

    // State register, timeout counter and captured address/data phases
    always_ff @(posedge i_sysclk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            rd_wr_n_r  <= 1'b0;
            addr_hi_r  <= 4'h0;
            addr_lo_r  <= 16'h0000;
            wdata_hi_r <= 16'h0000;
            rdata_r    <= 32'h0000_0000;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if ((state_r == ST_IDLE) && i_mib_start) begin
                rd_wr_n_r <= i_mib_rd_wr_n;
                addr_hi_r <= i_mib_ad[3:0];
            end
            if (state_r == ST_ADDR2) begin
                addr_lo_r <= i_mib_ad;
            end
            if (state_r == ST_WR_HI) begin
                wdata_hi_r <= i_mib_ad;
            end
            if (rdata_ld_s) begin
                rdata_r <= rdata_nxt_s;
            end
        end
    end

    // Registered MIB and cmd-bus outputs; nothing reaches a pad combinationally
    always_ff @(posedge i_sysclk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            o_mib_ad        <= 16'h0000;
            o_mib_ad_oe     <= 1'b0;
            o_mib_slave_ack <= 1'b0;
            o_cmd_sel       <= 1'b0;
            o_cmd_rd_wr_n   <= 1'b0;
            o_cmd_byte_addr <= 20'h00000;
            o_cmd_wdata     <= 32'h0000_0000;
            o_cmd_timeout   <= 1'b0;
        end else begin
            o_mib_ad_oe     <= rd_drive_s;
            o_mib_slave_ack <= wr_ack_s | rd_drive_s;
            o_cmd_sel       <= cmd_sel_s;
            o_cmd_timeout   <= timeout_s;
            if (state_s == ST_RD_HI) begin
                o_mib_ad <= rdata_r[31:16];
            end else if (state_s == ST_RD_LO) begin
                o_mib_ad <= rdata_r[15:0];
            end else begin
                o_mib_ad <= 16'h0000;
            end
            if (cmd_sel_s) begin
                o_cmd_rd_wr_n   <= rd_wr_n_r;
                o_cmd_byte_addr <= cmd_addr_s;
                if (!rd_wr_n_r) begin
                    o_cmd_wdata <= cmd_wdata_s;
                end
            end
        end
    end

`ifdef MIB_SLAVE_STATS_EN
    logic [15:0] stat_wr_cnt_r;
    logic [15:0] stat_rd_cnt_r;
    logic [15:0] stat_to_cnt_r;

    // Saturating transaction counters
    always_ff @(posedge i_sysclk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            stat_wr_cnt_r <= 16'h0000;
            stat_rd_cnt_r <= 16'h0000;
            stat_to_cnt_r <= 16'h0000;
        end else begin
            if (wr_ack_s && (stat_wr_cnt_r != 16'hFFFF)) begin
                stat_wr_cnt_r <= stat_wr_cnt_r + 16'h0001;
            end
            if ((state_r == ST_RD_LO) && (stat_rd_cnt_r != 16'hFFFF)) begin
                stat_rd_cnt_r <= stat_rd_cnt_r + 16'h0001;
            end
            if (timeout_s && (stat_to_cnt_r != 16'hFFFF)) begin
                stat_to_cnt_r <= stat_to_cnt_r + 16'h0001;
            end
        end
    end

    assign o_stat_wr_cnt = stat_wr_cnt_r;
    assign o_stat_rd_cnt = stat_rd_cnt_r;
    assign o_stat_to_cnt = stat_to_cnt_r;
`endif

endmodule

// File: tb/tb_mib_slave_bridge.sv
// Directed self-checking bench for mib_slave_bridge (P_SLAVE_MSN = 0, 16-clock cmd timeout).
module tb_mib_slave_bridge;

    logic        clk = 1'b0;
    logic        i_arst_n;
    logic        i_mib_start;
    logic        i_mib_rd_wr_n;
    logic [15:0] i_mib_ad;
    logic [15:0] o_mib_ad;
    logic        o_mib_ad_oe;
    logic        o_mib_slave_ack;
    logic        o_cmd_sel;
    logic        o_cmd_rd_wr_n;
    logic [19:0] o_cmd_byte_addr;
    logic [31:0] o_cmd_wdata;
    logic        i_cmd_ack;
    logic [31:0] i_cmd_rdata;
    logic        o_cmd_timeout;
`ifdef MIB_SLAVE_STATS_EN
    logic [15:0] o_stat_wr_cnt;
    logic [15:0] o_stat_rd_cnt;
    logic [15:0] o_stat_to_cnt;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mib_slave_bridge dut (
        .i_sysclk        (clk),
        .i_arst_n        (i_arst_n),
        .i_mib_start     (i_mib_start),
        .i_mib_rd_wr_n   (i_mib_rd_wr_n),
        .i_mib_ad        (i_mib_ad),
        .o_mib_ad        (o_mib_ad),
        .o_mib_ad_oe     (o_mib_ad_oe),
        .o_mib_slave_ack (o_mib_slave_ack),
        .o_cmd_sel       (o_cmd_sel),
        .o_cmd_rd_wr_n   (o_cmd_rd_wr_n),
        .o_cmd_byte_addr (o_cmd_byte_addr),
        .o_cmd_wdata     (o_cmd_wdata),
        .i_cmd_ack       (i_cmd_ack),
        .i_cmd_rdata     (i_cmd_rdata),
        .o_cmd_timeout   (o_cmd_timeout)
`ifdef MIB_SLAVE_STATS_EN
        ,
        .o_stat_wr_cnt   (o_stat_wr_cnt),
        .o_stat_rd_cnt   (o_stat_rd_cnt),
        .o_stat_to_cnt   (o_stat_to_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives address phases N and N+1; returns in cycle N+2
    task automatic mib_addr(input logic rd, input logic [23:0] a);
        i_mib_start   = 1'b1;
        i_mib_rd_wr_n = rd;
        i_mib_ad      = {8'h00, a[23:16]};
        tick();
        i_mib_start = 1'b0;
        i_mib_ad    = a[15:0];
        tick();
        i_mib_ad = 16'h0000;
    endtask

    task automatic wr_txn(input logic [23:0] a, input logic [31:0] d, input int ack_wait);
        mib_addr(1'b0, a);
        i_mib_ad = d[31:16];
        tick();
        i_mib_ad = d[15:0];
        tick();
        i_mib_ad = 16'h0000;
        repeat (ack_wait) tick();
        if (ack_wait < 16) begin
            i_cmd_ack = 1'b1;
            tick();
            i_cmd_ack = 1'b0;
        end
        repeat (6) tick();
    endtask

    task automatic rd_txn(input logic [23:0] a, input int ack_wait, input logic [31:0] rd);
        mib_addr(1'b1, a);
        repeat (ack_wait) tick();
        if (ack_wait < 16) begin
            i_cmd_ack   = 1'b1;
            i_cmd_rdata = rd;
            tick();
            i_cmd_ack = 1'b0;
        end
        repeat (6) tick();
    endtask

    task automatic test_reset();
        vectors++; if ({o_mib_ad_oe, o_mib_slave_ack, o_cmd_sel, o_cmd_timeout, o_cmd_rd_wr_n} !== 5'b00000) begin miscompares++; $display("FAIL rst_ctrl: got %b want 00000", {o_mib_ad_oe, o_mib_slave_ack, o_cmd_sel, o_cmd_timeout, o_cmd_rd_wr_n}); end
        vectors++; if (o_mib_ad !== 16'h0000) begin miscompares++; $display("FAIL rst_ad: got %h want 0000", o_mib_ad); end
        vectors++; if ({o_cmd_byte_addr, o_cmd_wdata} !== 52'h0) begin miscompares++; $display("FAIL rst_cmd: got %h/%h want 0/0", o_cmd_byte_addr, o_cmd_wdata); end
    endtask

    task automatic test_write();
        mib_addr(1'b0, 24'h000004);
        i_mib_ad = 16'h0101;
        tick();
        i_mib_ad = 16'h0202;
        tick();
        i_mib_ad = 16'h0000;
        // cycle N+4
        vectors++; if (o_cmd_sel !== 1'b1 || o_cmd_rd_wr_n !== 1'b0) begin miscompares++; $display("FAIL wr_sel: got sel=%b rdwrn=%b want 1/0", o_cmd_sel, o_cmd_rd_wr_n); end
        vectors++; if (o_cmd_byte_addr !== 20'h00004) begin miscompares++; $display("FAIL wr_addr: got %h want 00004", o_cmd_byte_addr); end
        vectors++; if (o_cmd_wdata !== 32'h01010202) begin miscompares++; $display("FAIL wr_data: got %h want 01010202", o_cmd_wdata); end
        vectors++; if (o_mib_slave_ack !== 1'b0) begin miscompares++; $display("FAIL wr_early_ack: got %b want 0", o_mib_slave_ack); end
        i_cmd_ack = 1'b1;
        tick();
        i_cmd_ack = 1'b0;
        // cycle N+5
        vectors++; if (o_mib_slave_ack !== 1'b1 || o_mib_ad_oe !== 1'b0 || o_cmd_sel !== 1'b0) begin miscompares++; $display("FAIL wr_ack: got ack=%b oe=%b sel=%b want 1/0/0", o_mib_slave_ack, o_mib_ad_oe, o_cmd_sel); end
        tick();
        vectors++; if (o_mib_slave_ack !== 1'b0) begin miscompares++; $display("FAIL wr_ack_len: got %b want 0", o_mib_slave_ack); end
        vectors++; if (o_cmd_wdata !== 32'h01010202) begin miscompares++; $display("FAIL wr_hold: got %h want 01010202", o_cmd_wdata); end
    endtask

    task automatic test_read_wait3();
        mib_addr(1'b1, 24'h012344);
        // cycle N+2
        vectors++; if (o_cmd_sel !== 1'b1 || o_cmd_rd_wr_n !== 1'b1 || o_cmd_byte_addr !== 20'h12344) begin miscompares++; $display("FAIL rd_sel: got sel=%b rdwrn=%b addr=%h want 1/1/12344", o_cmd_sel, o_cmd_rd_wr_n, o_cmd_byte_addr); end
        tick();
        // a start outside IDLE must not disturb the read
        i_mib_start   = 1'b1;
        i_mib_rd_wr_n = 1'b0;
        tick();
        i_mib_start = 1'b0;
        vectors++; if (o_mib_ad_oe !== 1'b0 || o_cmd_sel !== 1'b0) begin miscompares++; $display("FAIL rd_wait: got oe=%b sel=%b want 0/0", o_mib_ad_oe, o_cmd_sel); end
        tick();
        i_cmd_ack   = 1'b1;
        i_cmd_rdata = 32'hCAFE1234;
        tick();
        i_cmd_ack   = 1'b0;
        i_cmd_rdata = 32'h0;
        // cycle N+6: turnaround
        vectors++; if (o_mib_ad_oe !== 1'b0 || o_mib_slave_ack !== 1'b0) begin miscompares++; $display("FAIL rd_turn: got oe=%b ack=%b want 0/0", o_mib_ad_oe, o_mib_slave_ack); end
        tick();
        vectors++; if ({o_mib_ad_oe, o_mib_slave_ack, o_mib_ad} !== {2'b11, 16'hCAFE}) begin miscompares++; $display("FAIL rd_hi: got oe=%b ack=%b ad=%h want 1/1/cafe", o_mib_ad_oe, o_mib_slave_ack, o_mib_ad); end
        tick();
        vectors++; if ({o_mib_ad_oe, o_mib_slave_ack, o_mib_ad} !== {2'b11, 16'h1234}) begin miscompares++; $display("FAIL rd_lo: got oe=%b ack=%b ad=%h want 1/1/1234", o_mib_ad_oe, o_mib_slave_ack, o_mib_ad); end
        tick();
        vectors++; if (o_mib_ad_oe !== 1'b0 || o_mib_slave_ack !== 1'b0 || o_cmd_sel !== 1'b0) begin miscompares++; $display("FAIL rd_end: got oe=%b ack=%b sel=%b want 0/0/0", o_mib_ad_oe, o_mib_slave_ack, o_cmd_sel); end
        vectors++; if (o_cmd_byte_addr !== 20'h12344) begin miscompares++; $display("FAIL rd_addr_hold: got %h want 12344", o_cmd_byte_addr); end
    endtask

    task automatic test_foreign();
        logic seen;
        seen = 1'b0;
        mib_addr(1'b0, 24'h300004);
        i_mib_ad = 16'h1111;
        for (int k = 0; k < 8; k++) begin
            if (o_cmd_sel || o_mib_ad_oe || o_mib_slave_ack) seen = 1'b1;
            tick();
            i_mib_ad = 16'h0000;
        end
        vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL foreign_wr: got activity=%b want 0", seen); end
        mib_addr(1'b1, 24'hF00010);
        for (int k = 0; k < 8; k++) begin
            if (o_cmd_sel || o_mib_ad_oe || o_mib_slave_ack) seen = 1'b1;
            if (k == 2) i_cmd_ack = 1'b1;
            tick();
            i_cmd_ack = 1'b0;
        end
        vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL foreign_rd: got activity=%b want 0", seen); end
    endtask

    task automatic test_rd_timeout();
        logic early;
        early = 1'b0;
        mib_addr(1'b1, 24'h000010);
        for (int k = 0; k < 16; k++) begin
            if (o_cmd_timeout || o_mib_ad_oe) early = 1'b1;
            tick();
        end
        vectors++; if (early !== 1'b0) begin miscompares++; $display("FAIL rd_to_early: got %b want 0", early); end
        // cycle sel+16
        vectors++; if (o_cmd_timeout !== 1'b1) begin miscompares++; $display("FAIL rd_to_pulse: got %b want 1", o_cmd_timeout); end
        i_cmd_ack   = 1'b1;
        i_cmd_rdata = 32'h11112222;
        tick();
        i_cmd_ack = 1'b0;
        vectors++; if ({o_cmd_timeout, o_mib_ad_oe, o_mib_slave_ack, o_mib_ad} !== {3'b011, 16'hDEAD}) begin miscompares++; $display("FAIL rd_to_hi: got to=%b oe=%b ack=%b ad=%h want 0/1/1/dead", o_cmd_timeout, o_mib_ad_oe, o_mib_slave_ack, o_mib_ad); end
        tick();
        vectors++; if ({o_mib_ad_oe, o_mib_slave_ack, o_mib_ad} !== {2'b11, 16'hBEEF}) begin miscompares++; $display("FAIL rd_to_lo: got oe=%b ack=%b ad=%h want 1/1/beef", o_mib_ad_oe, o_mib_slave_ack, o_mib_ad); end
        tick();
        i_cmd_ack = 1'b1;
        tick();
        i_cmd_ack = 1'b0;
        vectors++; if ({o_cmd_sel, o_mib_slave_ack, o_cmd_timeout, o_mib_ad_oe} !== 4'b0000) begin miscompares++; $display("FAIL late_ack: got %b want 0000", {o_cmd_sel, o_mib_slave_ack, o_cmd_timeout, o_mib_ad_oe}); end
    endtask

    task automatic test_wr_timeout();
        logic early;
        early = 1'b0;
        mib_addr(1'b0, 24'h000020);
        i_mib_ad = 16'hAAAA;
        tick();
        i_mib_ad = 16'h5555;
        tick();
        i_mib_ad = 16'h0000;
        for (int k = 0; k < 16; k++) begin
            if (o_cmd_timeout || o_mib_slave_ack) early = 1'b1;
            tick();
        end
        vectors++; if (early !== 1'b0) begin miscompares++; $display("FAIL wr_to_early: got %b want 0", early); end
        vectors++; if (o_cmd_timeout !== 1'b1 || o_mib_slave_ack !== 1'b1) begin miscompares++; $display("FAIL wr_to: got to=%b ack=%b want 1/1", o_cmd_timeout, o_mib_slave_ack); end
        tick();
        vectors++; if (o_cmd_timeout !== 1'b0 || o_mib_slave_ack !== 1'b0) begin miscompares++; $display("FAIL wr_to_len: got to=%b ack=%b want 0/0", o_cmd_timeout, o_mib_slave_ack); end
    endtask

    task automatic test_reset_mid_read();
        mib_addr(1'b1, 24'h000008);
        i_cmd_ack   = 1'b1;
        i_cmd_rdata = 32'hA5A55A5A;
        tick();
        i_cmd_ack = 1'b0;
        tick();
        // cycle N+4: RD_HI
        vectors++; if (o_mib_ad_oe !== 1'b1 || o_mib_ad !== 16'hA5A5) begin miscompares++; $display("FAIL rst_pre: got oe=%b ad=%h want 1/a5a5", o_mib_ad_oe, o_mib_ad); end
        i_arst_n = 1'b0;
        #1;
        vectors++; if ({o_mib_ad_oe, o_mib_slave_ack, o_mib_ad} !== 18'h0) begin miscompares++; $display("FAIL rst_async: got oe=%b ack=%b ad=%h want 0/0/0000", o_mib_ad_oe, o_mib_slave_ack, o_mib_ad); end
        tick();
        tick();
        i_arst_n = 1'b1;
        repeat (3) tick();
        mib_addr(1'b0, 24'h0ABCD0);
        i_mib_ad = 16'h1357;
        tick();
        i_mib_ad = 16'h9BDF;
        tick();
        i_mib_ad = 16'h0000;
        vectors++; if (o_cmd_sel !== 1'b1 || o_cmd_byte_addr !== 20'hABCD0 || o_cmd_wdata !== 32'h13579BDF) begin miscompares++; $display("FAIL rst_after: got sel=%b addr=%h data=%h want 1/abcd0/13579bdf", o_cmd_sel, o_cmd_byte_addr, o_cmd_wdata); end
        i_cmd_ack = 1'b1;
        tick();
        i_cmd_ack = 1'b0;
        vectors++; if (o_mib_slave_ack !== 1'b1) begin miscompares++; $display("FAIL rst_after_ack: got %b want 1", o_mib_slave_ack); end
        repeat (2) tick();
    endtask

`ifdef MIB_SLAVE_STATS_EN
    task automatic test_stats();
        i_arst_n = 1'b0;
        tick();
        i_arst_n = 1'b1;
        repeat (3) tick();
        wr_txn(24'h000100, 32'h00000001, 0);
        wr_txn(24'h000104, 32'h00000002, 1);
        rd_txn(24'h000108, 2, 32'h12345678);
        rd_txn(24'h00010C, 20, 32'h0);
        vectors++; if ({o_stat_wr_cnt, o_stat_rd_cnt, o_stat_to_cnt} !== {16'd2, 16'd2, 16'd1}) begin miscompares++; $display("FAIL stats: got %0d/%0d/%0d want 2/2/1", o_stat_wr_cnt, o_stat_rd_cnt, o_stat_to_cnt); end
        force dut.stat_wr_cnt_r = 16'hFFFF;
        tick();
        release dut.stat_wr_cnt_r;
        wr_txn(24'h000110, 32'h00000003, 0);
        vectors++; if (o_stat_wr_cnt !== 16'hFFFF) begin miscompares++; $display("FAIL stats_sat: got %h want ffff", o_stat_wr_cnt); end
    endtask
`endif

    initial begin
        i_arst_n      = 1'b0;
        i_mib_start   = 1'b0;
        i_mib_rd_wr_n = 1'b0;
        i_mib_ad      = 16'h0000;
        i_cmd_ack     = 1'b0;
        i_cmd_rdata   = 32'h0;
        repeat (2) tick();
        test_reset();
        i_arst_n = 1'b1;
        repeat (3) tick();
        test_write();
        test_read_wait3();
        test_foreign();
        test_rd_timeout();
        test_wr_timeout();
        test_reset_mid_read();
`ifdef MIB_SLAVE_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
